// File: rtl/mem32x8_ctrl.sv
// Clocked word memory with per-entry even parity, registered read port,
// sticky read/write collision flag and saturating access counters.
module mem32x8_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_inject,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              proto_err,
    output logic              parity_err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Entry layout: {data, parity}; parity sits in bit 0.
    logic [DATA_W:0]   mem_q [DEPTH];
    logic [DATA_W-1:0] data_q, data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              proto_q, proto_d;
    logic              parity_err_q, parity_err_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              do_rd_s, do_wr_s;
    logic [DATA_W:0]   rd_word_s;

    // Next-state decode for the read port, flags and counters.
    always_comb begin
        do_rd_s      = read & ~write;
        do_wr_s      = write & ~read;
        rd_word_s    = mem_q[addr];
        data_d       = data_q;
        rd_valid_d   = 1'b0;
        parity_err_d = 1'b0;
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        proto_d      = proto_q | (read & write);
        if (do_rd_s) begin
            data_d       = rd_word_s[DATA_W:1];
            rd_valid_d   = 1'b1;
            parity_err_d = rd_word_s[0] ^ parity_of(rd_word_s[DATA_W:1]);
            rd_cnt_d     = sat_inc(rd_cnt_q);
        end else if (do_wr_s) begin
            wr_cnt_d     = sat_inc(wr_cnt_q);
        end else begin
            data_d       = data_q;
        end
    end

    // Storage array; a write is visible to a read sampled at the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_wr_s) begin
            mem_q[addr] <= {data_in, parity_of(data_in) ^ parity_inject};
        end
    end

    // Registered outputs and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q       <= '0;
            rd_valid_q   <= 1'b0;
            proto_q      <= 1'b0;
            parity_err_q <= 1'b0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
        end else begin
            data_q       <= data_d;
            rd_valid_q   <= rd_valid_d;
            proto_q      <= proto_d;
            parity_err_q <= parity_err_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    assign data_out   = data_q;
    assign rd_valid   = rd_valid_q;
    assign proto_err  = proto_q;
    assign parity_err = parity_err_q;
    assign rd_count   = rd_cnt_q;
    assign wr_count   = wr_cnt_q;

endmodule

// File: tb/tb_mem32x8_ctrl.sv
// Directed plus randomized bench for mem32x8_ctrl against an array-based
// reference model; a second instance with 4-bit counters covers saturation.
module tb_mem32x8_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [4:0] addr = 5'd0;
    logic [7:0] data_in = 8'd0;
    logic       parity_inject = 1'b0;

    logic [7:0]  dout_a, dout_b;
    logic        rv_a, rv_b, pro_a, pro_b, pe_a, pe_b;
    logic [15:0] rc_a, wc_a;
    logic [3:0]  rc_b, wc_b;

    mem32x8_ctrl #(.ADDR_W(5), .DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
        .data_in(data_in), .parity_inject(parity_inject),
        .data_out(dout_a), .rd_valid(rv_a), .proto_err(pro_a),
        .parity_err(pe_a), .rd_count(rc_a), .wr_count(wc_a)
    );

    mem32x8_ctrl #(.ADDR_W(5), .DATA_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
        .data_in(data_in), .parity_inject(parity_inject),
        .data_out(dout_b), .rd_valid(rv_b), .proto_err(pro_b),
        .parity_err(pe_b), .rd_count(rc_b), .wr_count(wc_b)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays and unbounded counts.
    int m_data [32];
    bit m_bad  [32];
    int m_dout, m_rc, m_wc;
    bit m_rv, m_pe, m_proto;

    int n_checks = 0;
    int n_err    = 0;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_data[i] = 0;
            m_bad[i]  = 1'b0;
        end
        m_dout = 0; m_rc = 0; m_wc = 0;
        m_rv = 1'b0; m_pe = 1'b0; m_proto = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".data_out"},   32'(dout_a), 32'(m_dout));
        chk({tag, ".rd_valid"},   32'(rv_a),   32'(m_rv));
        chk({tag, ".parity_err"}, 32'(pe_a),   32'(m_pe));
        chk({tag, ".proto_err"},  32'(pro_a),  32'(m_proto));
        chk({tag, ".rd_count"},   32'(rc_a),   32'(sat(m_rc, 65535)));
        chk({tag, ".wr_count"},   32'(wc_a),   32'(sat(m_wc, 65535)));
        chk({tag, ".rd_count4"},  32'(rc_b),   32'(sat(m_rc, 15)));
        chk({tag, ".wr_count4"},  32'(wc_b),   32'(sat(m_wc, 15)));
        chk({tag, ".data_out4"},  32'(dout_b), 32'(m_dout));
    endtask

    task automatic step(input string tag, input bit rd, input bit wr,
                        input int a, input int d, input bit inj);
        @(negedge clk);
        read = rd; write = wr; addr = 5'(a); data_in = 8'(d); parity_inject = inj;
        @(posedge clk);
        #1;
        m_rv = 1'b0;
        m_pe = 1'b0;
        if (rd && wr) begin
            m_proto = 1'b1;
        end else if (wr) begin
            m_data[a] = d & 255;
            m_bad[a]  = inj;
            m_wc++;
        end else if (rd) begin
            m_dout = m_data[a];
            m_rv   = 1'b1;
            m_pe   = m_bad[a];
            m_rc++;
        end
        compare_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; read = 1'b0; write = 1'b0; parity_inject = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset state and read-all of a freshly cleared array.
        @(negedge clk);
        @(negedge clk);
        compare_all("reset");
        rst = 1'b0;
        for (int i = 0; i < 32; i++) step("rd_after_reset", 1'b1, 1'b0, i, 0, 1'b0);
        chk("rd_count_32", 32'(rc_a), 32'd32);
        chk("wr_count_0",  32'(wc_a), 32'd0);

        // Write i*7 then read everything back.
        do_reset();
        for (int i = 0; i < 32; i++) step("wr_pattern", 1'b0, 1'b1, i, (i * 7) % 256, 1'b0);
        for (int i = 0; i < 32; i++) begin
            step("rd_pattern", 1'b1, 1'b0, i, 0, 1'b0);
            chk("readback", 32'(dout_a), 32'((i * 7) % 256));
        end
        chk("wr_count_32", 32'(wc_a), 32'd32);
        chk("rd_count_32b", 32'(rc_a), 32'd32);

        // Write followed by an immediate read of the same word.
        step("wr_a5", 1'b0, 1'b1, 5, 8'hA5, 1'b0);
        step("rd_a5", 1'b1, 1'b0, 5, 0, 1'b0);
        chk("immediate_read", 32'(dout_a), 32'h0000_00A5);

        // Collision edge: no access, counters frozen, sticky flag.
        step("wr_11", 1'b0, 1'b1, 3, 8'h11, 1'b0);
        step("collide", 1'b1, 1'b1, 3, 8'hFF, 1'b0);
        chk("proto_set", 32'(pro_a), 32'd1);
        step("idle_after_collide", 1'b0, 1'b0, 0, 0, 1'b0);
        step("rd_3", 1'b1, 1'b0, 3, 0, 1'b0);
        chk("collide_no_write", 32'(dout_a), 32'h0000_0011);
        chk("proto_sticky", 32'(pro_a), 32'd1);

        // Parity injection, single-cycle strobe, then clean rewrite.
        step("wr_bad_par", 1'b0, 1'b1, 9, 8'h3C, 1'b1);
        step("rd_bad_par", 1'b1, 1'b0, 9, 0, 1'b0);
        chk("parity_err_hi", 32'(pe_a), 32'd1);
        step("idle_par", 1'b0, 1'b0, 9, 0, 1'b0);
        chk("parity_err_one_cycle", 32'(pe_a), 32'd0);
        step("wr_good_par", 1'b0, 1'b1, 9, 8'h3C, 1'b0);
        step("rd_good_par", 1'b1, 1'b0, 9, 0, 1'b0);
        chk("parity_err_clean", 32'(pe_a), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 255)),
                 $urandom_range(0, 7) == 0);
        end

        // Asynchronous reset between edges while a read result is live.
        step("wr_async", 1'b0, 1'b1, 12, 8'h5A, 1'b0);
        step("rd_async", 1'b1, 1'b0, 12, 0, 1'b0);
        chk("rv_before_rst", 32'(rv_a), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rd_valid", 32'(rv_a), 32'd0);
        chk("async_data_out", 32'(dout_a), 32'd0);
        chk("async_rd_count", 32'(rc_a), 32'd0);
        chk("async_wr_count", 32'(wc_a), 32'd0);
        chk("async_proto",    32'(pro_a), 32'd0);
        model_reset();
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        rst = 1'b0;
        step("rd_after_async", 1'b1, 1'b0, 12, 0, 1'b0);
        chk("first_read_zero", 32'(dout_a), 32'd0);

        // Saturation of the 4-bit counter after 20 writes.
        do_reset();
        for (int i = 0; i < 20; i++) step("wr_sat", 1'b0, 1'b1, i, i + 1, 1'b0);
        chk("wr_count4_sat", 32'(wc_b), 32'h0000_000F);
        chk("wr_count16_20", 32'(wc_a), 32'd20);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
